// File: rtl/macc_sequencer_pkg.sv
// Shared definitions for the MACC sequencer: op codes, MACC latency, FSM states.
package macc_sequencer_pkg;

    // MACC op codes; bit0 selects the SQUARE variant of each op.
    localparam logic [2:0] OP_MULT = 3'b000;
    localparam logic [2:0] OP_MACC = 3'b010;
    localparam logic [2:0] OP_MADD = 3'b100;
    localparam logic [2:0] OP_SQ   = 3'b001;

    // Cycles from an issued op to the MACC output reflecting it.
    localparam int MACC_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/macc_sequencer_flag_delay.sv
// Fixed-depth shift register carrying {window_end, last} alongside the MACC
// pipeline, so the flags emerge in the cycle the MACC output is valid.
module flag_delay
    import macc_sequencer_pkg::*;
#(
    parameter int DEPTH = MACC_LATENCY,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flag_in,
    output logic [WIDTH-1:0] flag_out,
    output logic             nonempty
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift one stage per cycle; new flags enter at stage 0.
    always_comb begin
        stage_d[0] = flag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Any flag still in flight means the job has not fully drained.
    always_comb begin
        nonempty = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            nonempty = nonempty | (|stage_q[i]);
        end
    end

    // Stage registers, cleared so an aborted job leaves no stale flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign flag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/macc_sequencer.sv
// Control sequencer for the fixed-point MACC: accepts a job of num_out windows
// of kernel_len terms, gates the operand stream, and issues enable/op_code so
// each window starts a fresh sum. Window-end flags ride a delay line matched
// to the MACC latency to produce out_valid/out_last.
module macc_sequencer
    import macc_sequencer_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int CNT_W    = 16,
    parameter bit USE_BIAS = 1'b0,
    parameter bit SQUARE   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] kernel_len,
    input  logic [CNT_W-1:0] num_out,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             macc_enable,
    output logic             macc_clear,
    output logic [2:0]       macc_op_code,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] SQ_BITS  = SQUARE ? OP_SQ : 3'b000;
    localparam logic [2:0] FIRST_OP = (USE_BIAS ? OP_MADD : OP_MULT) | SQ_BITS;
    localparam logic [2:0] ACC_OP   = OP_MACC | SQ_BITS;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [LEN_W-1:0] term_q, term_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic             done_zero_q, done_zero_d;

    logic [1:0] flag_in;
    logic [1:0] flag_out;
    logic       pipe_busy;
    logic       lengths_ok;
    logic       window_end;
    logic       last_window;

    // Next-state, counter and output decode for the IDLE/RUN/DRAIN sequencer.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        num_d        = num_q;
        term_d       = term_q;
        win_d        = win_q;
        done_zero_d  = 1'b0;
        flag_in      = 2'b00;
        in_ready     = 1'b0;
        macc_enable  = 1'b0;
        macc_clear   = 1'b0;
        macc_op_code = OP_MULT;
        busy         = 1'b0;
        done         = done_zero_q;
        window_end   = 1'b0;
        last_window  = 1'b0;
        lengths_ok   = (kernel_len != '0) && (num_out != '0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lengths_ok) begin
                        len_d      = kernel_len;
                        num_d      = num_out;
                        term_d     = '0;
                        win_d      = '0;
                        macc_clear = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    macc_enable  = 1'b1;
                    macc_op_code = (term_q == '0) ? FIRST_OP : ACC_OP;
                    window_end   = (term_q == len_q - LEN_W'(1));
                    if (window_end) begin
                        term_d      = '0;
                        win_d       = win_q + CNT_W'(1);
                        last_window = (win_q == num_q - CNT_W'(1));
                        flag_in     = {1'b1, last_window};
                        if (last_window) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        term_d = term_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_busy) begin
                    busy = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            term_q      <= '0;
            win_q       <= '0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            term_q      <= term_d;
            win_q       <= win_d;
            done_zero_q <= done_zero_d;
        end
    end

    flag_delay #(
        .DEPTH (MACC_LATENCY),
        .WIDTH (2)
    ) u_flag_delay (
        .clk      (clk),
        .reset    (reset),
        .flag_in  (flag_in),
        .flag_out (flag_out),
        .nonempty (pipe_busy)
    );

    assign out_valid = flag_out[1];
    assign out_last  = flag_out[1] & flag_out[0];

endmodule
